// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Read-mode selectors and the threshold comparison used by the flag logic and its assertions.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // True when a word count has reached a threshold.
  function automatic bit fill_ge(input int fill, input int th);
    return fill >= th;
  endfunction

  // Legal parameter combination for a FIFO of 2**asize words.
  function automatic bit params_ok(input int asize, input int afull_th, input int aempty_th);
    int depth;
    if (asize < 1) return 1'b0;
    depth = 1 << asize;
    return (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th < depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DSIZE register array, one synchronous write port,
// one combinational read port, no reset.
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow
// and selectable standard or first-word-fall-through read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  output logic             o_wfull,
  output logic             o_walmost_full,
  input  logic             i_rd,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_rempty,
  output logic             o_ralmost_empty,
  output logic [ASIZE:0]   o_fill,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0]   FILL_ONE  = (ASIZE+1)'(1);
  localparam logic [ASIZE:0]   FILL_FULL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE-1:0] PTR_ONE   = ASIZE'(1);

  if (!params_ok(ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $fatal(1, "sync_fifo: illegal ASIZE/AFULL_TH/AEMPTY_TH combination");
  end

  logic             wr_ok;
  logic             rd_ok;
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic [ASIZE:0]   fill_nxt;
  logic [DSIZE-1:0] mem_rdata;

  // A full FIFO drops writes even when a read frees a slot in the same cycle.
  assign wr_ok = i_rst_n & i_wr & ~o_wfull;
  assign rd_ok = i_rst_n & i_rd & ~o_rempty;

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (i_wdata),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  always_comb begin
    fill_nxt = o_fill;
    case ({wr_ok, rd_ok})
      2'b10:   fill_nxt = o_fill + FILL_ONE;
      2'b01:   fill_nxt = o_fill - FILL_ONE;
      default: fill_nxt = o_fill;
    endcase
  end

  // Pointers, count and flags all derive from the same next-fill value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr            <= '0;
      rptr            <= '0;
      o_fill          <= '0;
      o_wfull         <= 1'b0;
      o_rempty        <= 1'b1;
      o_walmost_full  <= 1'b0;
      o_ralmost_empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      o_fill          <= fill_nxt;
      o_wfull         <= (fill_nxt == FILL_FULL);
      o_rempty        <= (fill_nxt == '0);
      o_walmost_full  <= fill_ge(int'(fill_nxt), AFULL_TH);
      o_ralmost_empty <= !fill_ge(int'(fill_nxt), AEMPTY_TH + 1);
    end
  end

  // Sticky error flags: a new error wins over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_wr & o_wfull)  | (o_overflow  & ~i_clr_err);
      o_underflow <= (i_rd & o_rempty) | (o_underflow & ~i_clr_err);
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign o_rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   rdata_p1 <= '0;
      else if (rd_ok) rdata_p1 <= mem_rdata;
    end

    assign o_rdata = rdata_p1;
  end

  a_fill_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    int'(o_fill) <= DEPTH);
  a_afull: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_walmost_full == fill_ge(int'(o_fill), AFULL_TH));
  a_aempty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_ralmost_empty == !fill_ge(int'(o_fill), AEMPTY_TH + 1));
  a_full_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_wfull && o_rempty));

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized bench for sync_fifo: a standard-read and an FWFT instance share
// stimulus and are checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int AEMPT = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_wr = 1'b0;
  logic [DSIZE-1:0] i_wdata = '0;
  logic             i_rd = 1'b0;
  logic             i_clr_err = 1'b0;

  logic             s_wfull, s_wafull, s_rempty, s_raempty, s_ovf, s_unf;
  logic [DSIZE-1:0] s_rdata;
  logic [ASIZE:0]   s_fill;
  logic             f_wfull, f_wafull, f_rempty, f_raempty, f_ovf, f_unf;
  logic [DSIZE-1:0] f_rdata;
  logic [ASIZE:0]   f_fill;

  int total = 0;
  int bad = 0;

  logic [DSIZE-1:0] q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  logic [DSIZE-1:0] m_std = '0;

  always #5 i_clk = ~i_clk;

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPT)) dut_std (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_wdata(i_wdata),
    .o_wfull(s_wfull), .o_walmost_full(s_wafull), .i_rd(i_rd), .o_rdata(s_rdata),
    .o_rempty(s_rempty), .o_ralmost_empty(s_raempty), .o_fill(s_fill),
    .o_overflow(s_ovf), .o_underflow(s_unf), .i_clr_err(i_clr_err));

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPT)) dut_fwft (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_wdata(i_wdata),
    .o_wfull(f_wfull), .o_walmost_full(f_wafull), .i_rd(i_rd), .o_rdata(f_rdata),
    .o_rempty(f_rempty), .o_ralmost_empty(f_raempty), .o_fill(f_fill),
    .o_overflow(f_ovf), .o_underflow(f_unf), .i_clr_err(i_clr_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill",    32'(s_fill),    32'(n));
    chk("wfull",   32'(s_wfull),   32'(n == DEPTH));
    chk("rempty",  32'(s_rempty),  32'(n == 0));
    chk("afull",   32'(s_wafull),  32'(n >= AFULL));
    chk("aempty",  32'(s_raempty), 32'(n <= AEMPT));
    chk("ovf",     32'(s_ovf),     32'(m_ovf));
    chk("unf",     32'(s_unf),     32'(m_unf));
    chk("rdata",   32'(s_rdata),   32'(m_std));
    chk("f_fill",  32'(f_fill),    32'(n));
    chk("f_rempty",32'(f_rempty),  32'(n == 0));
    chk("f_ovf",   32'(f_ovf),     32'(m_ovf));
    chk("f_unf",   32'(f_unf),     32'(m_unf));
    if (n > 0) chk("f_head", 32'(f_rdata), 32'(q[0]));
  endtask

  // Called at a falling edge; drives one cycle, updates the model, checks at the next falling edge.
  task automatic cycle(input bit wr, input logic [DSIZE-1:0] wd, input bit rd, input bit clr);
    bit full, empty;
    i_wr = wr; i_wdata = wd; i_rd = rd; i_clr_err = clr;
    @(posedge i_clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    m_ovf = (wr && full)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (rd && empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (rd && !empty) m_std = q.pop_front();
    if (wr && !full)  q.push_back(wd);
    @(negedge i_clk);
    i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_std = '0;
  endtask

  initial begin
    int wbias;
    // reset state
    repeat (2) @(negedge i_clk);
    check_all();
    i_rst_n = 1'b1;

    // fill with 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AFULL - 2) chk("afull_13", 32'(s_wafull), 32'd0);
      if (i == AFULL - 1) chk("afull_14", 32'(s_wafull), 32'd1);
    end
    chk("full16", 32'(s_wfull), 32'd1);
    chk("fill16", 32'(s_fill), 32'd16);

    // write while full with a read: write dropped, overflow set
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("after_drop_fill", 32'(s_fill), 32'd15);
    chk("first_pop", 32'(s_rdata), 32'h00);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain", 32'(s_rdata), 32'(i));
    end
    chk("drained_empty", 32'(s_rempty), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 32'd0);

    // registered read timing
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("std_before", 32'(s_rdata), 32'h0F);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("std_a5", 32'(s_rdata), 32'hA5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("std_hold", 32'(s_rdata), 32'hA5);

    // first-word-fall-through
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_ne", 32'(f_rempty), 32'd0);
    chk("fwft_3c", 32'(f_rdata), 32'h3C);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(f_rempty), 32'd1);

    // underflow with simultaneous clear: set wins
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_prio", 32'(s_unf), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // concurrent read/write across wraps at fill 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("stream_fill5", 32'(s_fill), 32'd5);
    end

    // random traffic with shifting bias
    for (int ph = 0; ph < 4; ph++) begin
      wbias = (ph == 0) ? 80 : (ph == 1) ? 25 : (ph == 2) ? 50 : 65;
      for (int i = 0; i < 100; i++)
        cycle(($urandom_range(0, 99) < wbias), 8'($urandom),
              ($urandom_range(0, 99) >= wbias - 10), ($urandom_range(0, 31) == 0));
    end

    // fill 9 with underflow pending, then reset between edges
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(s_unf), 32'd1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("fill9", 32'(s_fill), 32'd9);
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_fill", 32'(s_fill), 32'd0);
    chk("rst_rempty", 32'(s_rempty), 32'd1);
    chk("rst_unf", 32'(s_unf), 32'd0);
    check_all();
    // requests during reset are ignored
    i_wr = 1'b1; i_wdata = 8'h77; i_rd = 1'b1;
    @(negedge i_clk);
    i_wr = 1'b0; i_rd = 1'b0;
    check_all();
    i_rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_head", 32'(f_rdata), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rd", 32'(s_rdata), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE words.
REQ-003 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter AFULL_TH, default DEPTH-2, almost-full threshold in words.
REQ-005 Parameter AEMPTY_TH, default 2, almost-empty threshold in words.
REQ-006 i_clk  input  1  sole clock; every flop samples on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_wr  input  1  write request.
REQ-009 i_wdata  input  DSIZE  write data.
REQ-010 o_wfull  output  1  FIFO holds DEPTH words.
REQ-011 o_walmost_full  output  1  fill >= AFULL_TH.
REQ-012 i_rd  input  1  read request, or pop when FWFT=1.
REQ-013 o_rdata  output  DSIZE  read data.
REQ-014 o_rempty  output  1  FIFO holds 0 words.
REQ-015 o_ralmost_empty  output  1  fill <= AEMPTY_TH.
REQ-016 o_fill  output  ASIZE+1  current word count, 0..DEPTH.
REQ-017 o_overflow  output  1  sticky: a write was attempted while full.
REQ-018 o_underflow  output  1  sticky: a read was attempted while empty.
REQ-019 i_clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-020 A write SHALL be accepted iff i_wr=1 and o_wfull=0, as sampled at the edge; an accepted write stores i_wdata at the write pointer, and the write pointer then increments modulo DEPTH.
REQ-021 A read SHALL be accepted iff i_rd=1 and o_rempty=0; the read pointer then increments modulo DEPTH.
REQ-022 o_fill SHALL increment on write-only, decrement on read-only, and stay unchanged when a read and a write are both accepted in the same cycle.
REQ-023 A write requested while full SHALL be dropped, even if a read is accepted in the same cycle.
REQ-024 o_wfull, o_rempty, o_walmost_full and o_ralmost_empty SHALL be registered and SHALL reflect the o_fill value produced by the same edge.
REQ-025 FWFT=0: o_rdata SHALL update one cycle after the accepting edge with the popped word, and SHALL hold its value otherwise.
REQ-026 FWFT=1: o_rdata SHALL present the head word whenever o_rempty=0; the first write into an empty FIFO SHALL be visible after that write's edge; i_rd pops the head word.
REQ-027 o_overflow SHALL set on i_wr=1 while o_wfull=1; o_underflow SHALL set on i_rd=1 while o_rempty=1; both SHALL clear on i_clr_err=1, and a set takes priority over a clear in the same cycle.
REQ-028 Data order SHALL be preserved across any number of pointer wrap-arounds.
REQ-029 Elaboration SHALL fail unless 1 <= AFULL_TH <= DEPTH, 0 <= AEMPTY_TH < DEPTH, and ASIZE >= 1.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately clear both pointers, o_fill, o_overflow, o_underflow, and, when FWFT=0, o_rdata.
REQ-031 During reset, o_rempty=1, o_ralmost_empty=1, o_wfull=0, and o_walmost_full=0.
REQ-032 Storage SHALL NOT be reset; a reset asserted mid-operation SHALL discard all contents, and requests are ignored while reset is asserted.

Structure
REQ-033 Package fifo_pkg SHALL hold the read-mode constants FIFO_STD=0 and FIFO_FWFT=1, plus a threshold-check function reused by the assertions.
REQ-034 Storage SHALL be a sub-module fifo_mem: a DEPTH x DSIZE register array with one synchronous write port and one combinational read port, and no reset.
REQ-035 Pointer, count, flag and output-register logic SHALL live in sync_fifo.

Verification (DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-036 After reset, write 0x00..0x0F on consecutive cycles -> o_walmost_full=1 after the 14th write, o_wfull=1 and o_fill=16 after the 16th write.
REQ-037 While full, write 0xFF with i_rd=1 -> the write is dropped and o_overflow=1; draining the FIFO returns 0x00..0x0F in order and ends with o_rempty=1.
REQ-038 FWFT=0: write 0xA5, then read -> o_rdata=0xA5 exactly one cycle after the accepting edge, held until the next read.
REQ-039 FWFT=1: write 0x3C into an empty FIFO -> after that edge o_rempty=0 and o_rdata=0x3C with i_rd=0; pulse i_rd -> o_rempty=1.
REQ-040 At fill=5, stream 40 simultaneous reads and writes -> o_fill stays 5 throughout and the read sequence equals the write sequence across the wraps.
REQ-041 At fill=9 with o_underflow=1, drive i_rst_n=0 between edges -> o_fill=0, o_rempty=1 and o_underflow=0 before the next edge.
